// File: rtl/phy_pkg.sv
// phy_pkg: symbol constants and receiver state shared by the serial link ends
package phy_pkg;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int BC_COUNT = 4;
  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_e;
endpackage

// File: rtl/serial_paralelo_rx_comma_detect.sv
// comma_detect: flags the byte completed by the current bit as comma or idle
module comma_detect #(
  parameter logic [7:0] COMMA = phy_pkg::COMMA,
  parameter logic [7:0] IDLE = phy_pkg::IDLE
) (
  input  logic [7:0] nxt,
  output logic       is_comma,
  output logic       is_idle
);
  assign is_comma = (nxt == COMMA);
  assign is_idle = (nxt == IDLE);
endmodule

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: comma-aligned serial-to-parallel byte receiver
module serial_paralelo_rx #(
  parameter logic [7:0] COMMA = phy_pkg::COMMA,
  parameter logic [7:0] IDLE = phy_pkg::IDLE,
  parameter int BC_COUNT = phy_pkg::BC_COUNT
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);
  import phy_pkg::*;
  localparam logic [3:0] BC_TGT = 4'(BC_COUNT);
  state_e state_q, state_d;
  logic [7:0] sr_q, sr_d, data_q, data_d, nxt;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d, bc_inc;
  logic valid_q, valid_d, strobe_q, strobe_d, active_q, active_d;
  logic is_comma, is_idle;
  assign nxt = {sr_q[6:0], data_in};
  comma_detect #(.COMMA(COMMA), .IDLE(IDLE)) u_det (
    .nxt(nxt),
    .is_comma(is_comma),
    .is_idle(is_idle)
  );
  always_comb begin
    sr_d = nxt;
    state_d = state_q;
    bit_cnt_d = (state_q == SEARCH) ? bit_cnt_q : bit_cnt_q + 3'd1;
    bc_cnt_d = bc_cnt_q;
    bc_inc = (bc_cnt_q == 4'hF) ? 4'hF : bc_cnt_q + 4'd1;
    data_d = data_q;
    valid_d = valid_q;
    strobe_d = 1'b0;
    active_d = active_q;
    case (state_q)
      SEARCH: if (is_comma) begin
        bit_cnt_d = 3'd0;
        bc_cnt_d = 4'd1;
        state_d = (BC_TGT == 4'd1) ? LOCKED : ALIGN;
        active_d = (BC_TGT == 4'd1);
      end
      ALIGN: if (bit_cnt_q == 3'd7) begin
        if (is_comma) begin
          bc_cnt_d = bc_inc;
          if (bc_inc == BC_TGT) begin
            state_d = LOCKED;
            active_d = 1'b1;
          end
        end else begin
          bc_cnt_d = 4'd0;
          state_d = SEARCH;
        end
      end
      LOCKED: if (bit_cnt_q == 3'd7) begin
        data_d = nxt;
        valid_d = !is_comma && !is_idle;
        strobe_d = 1'b1;
      end
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state_q <= SEARCH;
      sr_q <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q <= bc_cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      strobe_q <= strobe_d;
      active_q <= active_d;
    end
  end
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign byte_strobe = strobe_q;
  assign active = active_q;
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: randomized bench with an index-arithmetic alignment model
module tb_serial_paralelo_rx;
  logic clk_32f = 1'b0, reset_L = 1'b0, data_in = 1'b0;
  logic [7:0] d4, d1;
  logic v4, v1, s4, s1, a4, a1;
  int errors = 0, checks = 0;
  bit bits[$];
  always #5 clk_32f = ~clk_32f;
  serial_paralelo_rx #(.BC_COUNT(4)) u4 (
    .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in),
    .data_out(d4), .valid_out(v4), .byte_strobe(s4), .active(a4)
  );
  serial_paralelo_rx #(.BC_COUNT(1)) u1 (
    .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in),
    .data_out(d1), .valid_out(v1), .byte_strobe(s1), .active(a1)
  );
  function automatic void push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
  endfunction
  function automatic void push_rand_bits(input int n);
    for (int i = 0; i < n; i++) bits.push_back(bit'($urandom_range(0, 1)));
  endfunction
  // byte whose last bit is stream index t (bits before the segment are zero)
  function automatic logic [7:0] win(input int t);
    logic [7:0] w = '0;
    for (int i = t - 7; i <= t; i++) w = {w[6:0], (i >= 0 && i < bits.size()) ? bits[i] : 1'b0};
    return w;
  endfunction
  // index of the bit on which the link locks, or -1
  function automatic int find_lock(input int bc);
    int t = 0;
    while (t < bits.size()) begin
      if (win(t) == 8'hBC) begin
        int j;
        j = 1;
        while (j < bc && t + 8 * j < bits.size() && win(t + 8 * j) == 8'hBC) j++;
        if (j == bc) return t + 8 * (bc - 1);
        if (t + 8 * j >= bits.size()) return -1;
        t = t + 8 * j + 1;
      end else t++;
    end
    return -1;
  endfunction
  function automatic logic [10:0] expect_at(input int l, input int t);
    logic [7:0] d = '0;
    logic v = 1'b0;
    if (l < 0 || t < l) return 11'h0;
    if (t - l >= 8) begin
      d = win(l + 8 * ((t - l) / 8));
      v = (d != 8'hBC) && (d != 8'h7C);
    end
    return {1'b1, (t > l) && ((t - l) % 8 == 0), v, d};
  endfunction
  task automatic run_seg(input string name, output int n4, output int n1);
    int l4, l1;
    logic [10:0] e4, e1;
    l4 = find_lock(4);
    l1 = find_lock(1);
    n4 = 0;
    n1 = 0;
    for (int t = 0; t < bits.size(); t++) begin
      data_in = bits[t];
      @(posedge clk_32f);
      #1;
      e4 = expect_at(l4, t);
      e1 = expect_at(l1, t);
      checks += 2;
      if ({a4, s4, v4, d4} !== e4) begin
        errors++;
        $display("FAIL %s bc4 t=%0d got a/s/v/d=%b%b%b/%h want %b%b%b/%h", name, t, a4, s4, v4, d4, e4[10], e4[9], e4[8], e4[7:0]);
      end
      if ({a1, s1, v1, d1} !== e1) begin
        errors++;
        $display("FAIL %s bc1 t=%0d got a/s/v/d=%b%b%b/%h want %b%b%b/%h", name, t, a1, s1, v1, d1, e1[10], e1[9], e1[8], e1[7:0]);
      end
      n4 += int'(s4);
      n1 += int'(s1);
    end
  endtask
  task automatic do_reset(input int n, input string name);
    logic [7:0] bc = 8'hBC;
    reset_L = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_in = bc[7 - (i % 8)];
      @(posedge clk_32f);
      #1;
      checks += 2;
      if ({a4, s4, v4, d4} !== 11'h0) begin
        errors++;
        $display("FAIL %s bc4 cyc=%0d got a/s/v/d=%b%b%b/%h want 000/00", name, i, a4, s4, v4, d4);
      end
      if ({a1, s1, v1, d1} !== 11'h0) begin
        errors++;
        $display("FAIL %s bc1 cyc=%0d got a/s/v/d=%b%b%b/%h want 000/00", name, i, a1, s1, v1, d1);
      end
    end
    reset_L = 1'b1;
  endtask
  task automatic test_reset;
    do_reset(16, "reset");
  endtask
  task automatic test_acquisition;
    int n4, n1;
    do_reset(2, "acq_rst");
    bits.delete();
    bits.push_back(1); bits.push_back(0); bits.push_back(1);
    repeat (4) push_byte(8'hBC);
    repeat (3) push_byte(8'h7C);
    push_byte(8'hFF);
    push_rand_bits(4);
    run_seg("acq", n4, n1);
    checks += 2;
    if (n4 != 4) begin errors++; $display("FAIL acq_strobes got %0d want 4", n4); end
    if ({a4, v4, d4} !== {2'b11, 8'hFF}) begin errors++; $display("FAIL acq_last got a=%b v=%b d=%h want 1 1 ff", a4, v4, d4); end
  endtask
  task automatic test_broken;
    int n4, n1;
    do_reset(2, "brk_rst");
    bits.delete();
    repeat (2) push_byte(8'hBC);
    push_byte(8'h55);
    repeat (4) push_byte(8'hBC);
    push_byte(8'hFF);
    push_rand_bits(4);
    run_seg("broken", n4, n1);
    checks++;
    if (n4 != 1) begin errors++; $display("FAIL broken_strobes got %0d want 1", n4); end
  endtask
  task automatic test_data;
    int n4, n1;
    logic [7:0] pay[6] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    do_reset(2, "data_rst");
    bits.delete();
    repeat (4) push_byte(8'hBC);
    foreach (pay[i]) push_byte(pay[i]);
    push_rand_bits(5);
    run_seg("data", n4, n1);
    checks += 2;
    if (n4 != 6) begin errors++; $display("FAIL data_strobes got %0d want 6", n4); end
    if (d4 !== 8'hAA) begin errors++; $display("FAIL data_last got %h want aa", d4); end
  endtask
  task automatic test_reset_mid;
    int n4, n1;
    do_reset(2, "mid_rst0");
    bits.delete();
    repeat (4) push_byte(8'hBC);
    push_byte(8'hFF);
    bits.push_back(0); bits.push_back(0); bits.push_back(1); bits.push_back(1);
    run_seg("mid_pre", n4, n1);
    do_reset(1, "mid_reset");
    bits.delete();
    repeat (3) push_byte(8'hBC);
    push_byte(8'hA5);
    repeat (4) push_byte(8'hBC);
    push_byte(8'h3C);
    push_rand_bits(3);
    run_seg("mid_relock", n4, n1);
    checks++;
    if (n4 != 1 || d4 !== 8'h3C) begin errors++; $display("FAIL mid_relock got n=%0d d=%h want 1 3c", n4, d4); end
  endtask
  task automatic test_bc1;
    int n4, n1;
    do_reset(2, "bc1_rst");
    bits.delete();
    push_byte(8'hBC);
    push_byte(8'h42);
    push_rand_bits(6);
    run_seg("bc1", n4, n1);
    checks += 2;
    if (n1 != 1 || {a1, v1, d1} !== {2'b11, 8'h42}) begin errors++; $display("FAIL bc1_final got n=%0d a=%b v=%b d=%h want 1 1 1 42", n1, a1, v1, d1); end
    if (a4 !== 1'b0) begin errors++; $display("FAIL bc1_bc4_inactive got %b want 0", a4); end
  endtask
  task automatic test_random;
    int n4, n1;
    for (int k = 0; k < 20; k++) begin
      do_reset(2, "rnd_rst");
      bits.delete();
      push_rand_bits($urandom_range(0, 7));
      repeat ($urandom_range(3, 5)) push_byte(8'hBC);
      repeat ($urandom_range(1, 8)) push_byte(($urandom_range(0, 3) == 0) ? 8'h7C : 8'($urandom));
      push_rand_bits($urandom_range(0, 7));
      run_seg("random", n4, n1);
    end
  endtask
  initial begin
    test_reset();
    test_acquisition();
    test_broken();
    test_data();
    test_reset_mid();
    test_bc1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
